// File: rtl/dcache_write_checker_pkg.sv
// Shared definitions for the D-cache write checker: FSM state encoding and a
// saturation helper.
package dcache_write_checker_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2,
        ST_TOUT  = 2'd3
    } state_t;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/dcache_ans_table.sv
// Golden answer table: register file with one write port, an indexed read,
// and an address CAM that reports the lowest matching entry.
module dcache_ans_table #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int N_ANS  = 16
) (
    input  logic                             clk,
    input  logic                             wr_en,
    input  logic [$clog2(N_ANS)-1:0]         wr_idx,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [$clog2(N_ANS)-1:0]         rd_idx,
    output logic [ADDR_W-1:0]                rd_addr,
    output logic [DATA_W-1:0]                rd_data,
    input  logic [ADDR_W-1:0]                key,
    output logic                             hit,
    output logic [$clog2(N_ANS)-1:0]         hit_idx,
    output logic [N_ANS-1:0][DATA_W-1:0]     all_data
);
    localparam int IDX_W = $clog2(N_ANS);

    logic [ADDR_W-1:0] tab_addr [N_ANS];
    logic [DATA_W-1:0] tab_data [N_ANS];

    // Contents survive reset so a rerun needs no reload.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tab_addr[wr_idx] <= wr_addr;
            tab_data[wr_idx] <= wr_data;
        end
    end

    assign rd_addr = tab_addr[rd_idx];
    assign rd_data = tab_data[rd_idx];

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_ANS - 1; i >= 0; i--) begin
            if (tab_addr[i] == key) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        all_data = '0;
        for (int i = 0; i < N_ANS; i++) all_data[i] = tab_data[i];
    end

endmodule

// File: rtl/dcache_write_checker.sv
// Snoops D-cache writes and scores them against a loadable golden table,
// either in write order or matched by address, with a hardware timeout.
module dcache_write_checker
    import dcache_write_checker_pkg::*;
#(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int N_ANS    = 16,
    parameter int ERR_W    = 8,
    parameter int DUR_W    = 16,
    parameter int TIMEOUT  = 10000,
    parameter int IN_ORDER = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data,
    input  logic                     wen,
    input  logic                     ld_en,
    input  logic [$clog2(N_ANS)-1:0] ld_idx,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [ERR_W-1:0]         error_num,
    output logic [DUR_W-1:0]         duration,
    output logic                     finish,
    output logic                     timeout,
    output logic [1:0]               curstate
);
    localparam int IDX_W = $clog2(N_ANS);
    localparam int CNT_W = $clog2(N_ANS + 1);

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [N_ANS-1:0]           seen, seen_nxt;
    logic [N_ANS-1:0][DATA_W-1:0] last, last_nxt, exp_data;
    logic [ADDR_W-1:0]          rd_addr;
    logic [DATA_W-1:0]          rd_data;
    logic                       hit;
    logic [IDX_W-1:0]           hit_idx;
    logic [CNT_W-1:0]           mism_cnt;
    logic [ERR_W-1:0]           err_inc, err_final;
    logic                       active, tmo_hit;

    dcache_ans_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_ANS(N_ANS)) u_table (
        .clk      (clk),
        .wr_en    (ld_en && (state == ST_WAIT)),
        .wr_idx   (ld_idx),
        .wr_addr  (ld_addr),
        .wr_data  (ld_data),
        .rd_idx   (idx),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .key      (addr),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .all_data (exp_data)
    );

    assign active   = (state == ST_WAIT) || (state == ST_CHECK);
    assign tmo_hit  = active && (duration == DUR_W'(TIMEOUT - 1));
    assign err_inc  = (error_num == '1) ? error_num : error_num + ERR_W'(1);
    assign curstate = state;

    // Out-of-order scoring: fold the current write in, then count mismatches
    // over the whole table so the final error count lands with finish.
    always_comb begin
        seen_nxt = seen;
        last_nxt = last;
        mism_cnt = '0;
        if (hit) begin
            seen_nxt[hit_idx] = 1'b1;
            last_nxt[hit_idx] = data;
        end
        for (int i = 0; i < N_ANS; i++)
            mism_cnt = mism_cnt + CNT_W'(last_nxt[i] != exp_data[i]);
        err_final = (int'(mism_cnt) > sat_max(ERR_W)) ? '1 : ERR_W'(mism_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_WAIT;
            error_num <= '0;
            duration  <= '0;
            finish    <= 1'b0;
            timeout   <= 1'b0;
            idx       <= '0;
            seen      <= '0;
            last      <= '0;
        end else if (active) begin
            if (tmo_hit) begin
                state   <= ST_TOUT;
                timeout <= 1'b1;
            end else begin
                duration <= duration + DUR_W'(1);
                if (wen) begin
                    state <= ST_CHECK;
                    if (IN_ORDER != 0) begin
                        if ({addr, data} != {rd_addr, rd_data}) error_num <= err_inc;
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(N_ANS - 1)) begin
                            state  <= ST_DONE;
                            finish <= 1'b1;
                        end
                    end else begin
                        seen <= seen_nxt;
                        last <= last_nxt;
                        if (&seen_nxt) begin
                            state     <= ST_DONE;
                            finish    <= 1'b1;
                            error_num <= err_final;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_write_checker.sv
// Bench for dcache_write_checker: three configurations share one stimulus
// stream; directed scenarios plus randomized runs scored by an outcome model.
module tb_dcache_write_checker;

    logic        clk, rst, wen, ld_en;
    logic [29:0] addr, ld_addr;
    logic [31:0] data, ld_data;
    logic [2:0]  ld_idx;

    logic [7:0]  err_io, err_ooo;
    logic [1:0]  err_sat;
    logic [15:0] dur_io, dur_ooo, dur_sat;
    logic        fin_io, fin_ooo, fin_sat, tout_io, tout_ooo, tout_sat;
    logic [1:0]  st_io, st_ooo, st_sat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [29:0] ga [8];
    logic [31:0] gd [8];
    logic [29:0] wa [$];
    logic [31:0] wd [$];
    int          wt [$];

    dcache_write_checker #(.N_ANS(4), .TIMEOUT(50), .IN_ORDER(1)) dut_io (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ld_en(ld_en & ~ld_idx[2]), .ld_idx(ld_idx[1:0]), .ld_addr(ld_addr), .ld_data(ld_data),
        .error_num(err_io), .duration(dur_io), .finish(fin_io), .timeout(tout_io), .curstate(st_io));

    dcache_write_checker #(.N_ANS(4), .TIMEOUT(50), .IN_ORDER(0)) dut_ooo (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ld_en(ld_en & ~ld_idx[2]), .ld_idx(ld_idx[1:0]), .ld_addr(ld_addr), .ld_data(ld_data),
        .error_num(err_ooo), .duration(dur_ooo), .finish(fin_ooo), .timeout(tout_ooo), .curstate(st_ooo));

    dcache_write_checker #(.N_ANS(8), .ERR_W(2), .TIMEOUT(200), .IN_ORDER(1)) dut_sat (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr), .ld_data(ld_data),
        .error_num(err_sat), .duration(dur_sat), .finish(fin_sat), .timeout(tout_sat), .curstate(st_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; wen = 1'b0; ld_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        wa.delete(); wd.delete(); wt.delete();
    endtask

    task automatic load(input int i, input logic [29:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_idx = i[2:0]; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
        ga[i] = a; gd[i] = d;
    endtask

    task automatic write(input logic [29:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; data = d;
        step();
        wen = 1'b0;
        wa.push_back(a); wd.push_back(d); wt.push_back(cyc);
    endtask

    task automatic load_std();
        for (int i = 0; i < 8; i++) load(i, 30'(32'h10 + i), 32'(i + 1));
    endtask

    // Outcome model: walk the logged writes (edge numbers count from reset
    // release) and decide who resolves first, the table or the timeout.
    task automatic model(input int n, input int tmo, input int errw, input bit inord,
                         output int e_err, output int e_dur, output bit e_fin);
        int errs, k, hit;
        bit done, all_seen;
        bit seen [8];
        logic [31:0] last [8];
        errs = 0; k = 0; done = 1'b0; e_dur = tmo - 1;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        for (int j = 0; j < wa.size(); j++) begin
            if (done || wt[j] >= tmo) break;
            if (inord) begin
                if (wa[j] !== ga[k] || wd[j] !== gd[k]) errs++;
                k++;
                if (k == n) begin done = 1'b1; e_dur = wt[j]; end
            end else begin
                hit = -1;
                for (int i = n - 1; i >= 0; i--) if (ga[i] === wa[j]) hit = i;
                if (hit >= 0) begin seen[hit] = 1'b1; last[hit] = wd[j]; end
                all_seen = 1'b1;
                for (int i = 0; i < n; i++) all_seen &= seen[i];
                if (all_seen) begin
                    done = 1'b1; e_dur = wt[j]; errs = 0;
                    for (int i = 0; i < n; i++) if (last[i] !== gd[i]) errs++;
                end
            end
        end
        if (!done && !inord) errs = 0;
        e_fin = done;
        e_err = (errs > (1 << errw) - 1) ? (1 << errw) - 1 : errs;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 3;
        if ({err_io, dur_io, fin_io, tout_io, st_io} !== '0) begin failures++; $display("FAIL reset_io got=%h exp=0", {err_io, dur_io, fin_io, tout_io, st_io}); end
        if ({err_ooo, dur_ooo, fin_ooo, tout_ooo, st_ooo} !== '0) begin failures++; $display("FAIL reset_ooo got=%h exp=0", {err_ooo, dur_ooo, fin_ooo, tout_ooo, st_ooo}); end
        if ({err_sat, dur_sat, fin_sat, tout_sat, st_sat} !== '0) begin failures++; $display("FAIL reset_sat got=%h exp=0", {err_sat, dur_sat, fin_sat, tout_sat, st_sat}); end
    endtask

    task automatic test_in_order();
        do_reset();
        load_std();
        for (int i = 0; i < 4; i++) write(ga[i], gd[i]);
        step();
        checks += 4;
        if (fin_io !== 1'b1) begin failures++; $display("FAIL io_finish got=%b exp=1", fin_io); end
        if (32'(err_io) !== 0) begin failures++; $display("FAIL io_err got=%0d exp=0", err_io); end
        if (32'(st_io) !== 2) begin failures++; $display("FAIL io_state got=%0d exp=2", st_io); end
        if (32'(dur_io) !== 12) begin failures++; $display("FAIL io_dur got=%0d exp=12", dur_io); end
    endtask

    task automatic test_mismatch();
        do_reset();
        write(30'h10, 32'd1); write(30'h11, 32'd2); write(30'h12, 32'hFF);
        wen = 1'b1; addr = 30'h13; data = 32'd4;
        checks += 2;
        if (fin_io !== 1'b0) begin failures++; $display("FAIL mm_early_finish got=%b exp=0", fin_io); end
        if (32'(err_io) !== 1) begin failures++; $display("FAIL mm_err_live got=%0d exp=1", err_io); end
        step();
        wen = 1'b0;
        checks += 4;
        if (fin_io !== 1'b1) begin failures++; $display("FAIL mm_finish got=%b exp=1", fin_io); end
        if (32'(err_io) !== 1) begin failures++; $display("FAIL mm_err got=%0d exp=1", err_io); end
        if (32'(st_io) !== 2) begin failures++; $display("FAIL mm_state got=%0d exp=2", st_io); end
        if (32'(dur_io) !== 4) begin failures++; $display("FAIL mm_dur got=%0d exp=4", dur_io); end
    endtask

    task automatic test_ooo();
        do_reset();
        write(30'h13, 32'd4); write(30'h10, 32'd1); write(30'h99, 32'd0);
        write(30'h12, 32'd3);
        checks += 1;
        if (fin_ooo !== 1'b0) begin failures++; $display("FAIL ooo_early_finish got=%b exp=0", fin_ooo); end
        write(30'h11, 32'd2);
        checks += 4;
        if (fin_ooo !== 1'b1) begin failures++; $display("FAIL ooo_finish got=%b exp=1", fin_ooo); end
        if (32'(err_ooo) !== 0) begin failures++; $display("FAIL ooo_err got=%0d exp=0", err_ooo); end
        if (32'(st_ooo) !== 2) begin failures++; $display("FAIL ooo_state got=%0d exp=2", st_ooo); end
        if (32'(dur_ooo) !== 5) begin failures++; $display("FAIL ooo_dur got=%0d exp=5", dur_ooo); end
    endtask

    task automatic test_latest();
        do_reset();
        write(30'h11, 32'd7); write(30'h10, 32'd1); write(30'h12, 32'd3);
        write(30'h11, 32'd2); write(30'h13, 32'd4);
        checks += 2;
        if (fin_ooo !== 1'b1) begin failures++; $display("FAIL latest_ok_finish got=%b exp=1", fin_ooo); end
        if (32'(err_ooo) !== 0) begin failures++; $display("FAIL latest_ok_err got=%0d exp=0", err_ooo); end
        do_reset();
        write(30'h11, 32'd2); write(30'h10, 32'd1); write(30'h11, 32'd7);
        write(30'h12, 32'd3); write(30'h13, 32'd4);
        checks += 2;
        if (fin_ooo !== 1'b1) begin failures++; $display("FAIL latest_bad_finish got=%b exp=1", fin_ooo); end
        if (32'(err_ooo) !== 1) begin failures++; $display("FAIL latest_bad_err got=%0d exp=1", err_ooo); end
    endtask

    task automatic test_timeout();
        do_reset();
        write(30'h10, 32'd1); write(30'h11, 32'd2);
        while (cyc < 49) step();
        checks += 2;
        if (tout_io !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", tout_io); end
        if (32'(dur_io) !== 49) begin failures++; $display("FAIL to_dur_pre got=%0d exp=49", dur_io); end
        write(30'h12, 32'hBAD);
        checks += 6;
        if (tout_io !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", tout_io); end
        if (fin_io !== 1'b0) begin failures++; $display("FAIL to_finish got=%b exp=0", fin_io); end
        if (32'(st_io) !== 3) begin failures++; $display("FAIL to_state got=%0d exp=3", st_io); end
        if (32'(dur_io) !== 49) begin failures++; $display("FAIL to_dur got=%0d exp=49", dur_io); end
        if (32'(err_io) !== 0) begin failures++; $display("FAIL to_err got=%0d exp=0", err_io); end
        if (tout_ooo !== 1'b1) begin failures++; $display("FAIL to_ooo_flag got=%b exp=1", tout_ooo); end
        write(30'h13, 32'hBAD);
        step();
        checks += 3;
        if (32'(err_io) !== 0) begin failures++; $display("FAIL to_hold_err got=%0d exp=0", err_io); end
        if (32'(dur_io) !== 49) begin failures++; $display("FAIL to_hold_dur got=%0d exp=49", dur_io); end
        if ({tout_io, fin_io, st_io} !== 4'b1011) begin failures++; $display("FAIL to_hold_flags got=%b exp=1011", {tout_io, fin_io, st_io}); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) write(ga[i], gd[i] ^ 32'hFF);
        checks += 2;
        if (32'(err_sat) !== 3) begin failures++; $display("FAIL sat_err got=%0d exp=3", err_sat); end
        if (32'(st_sat) !== 1) begin failures++; $display("FAIL sat_state got=%0d exp=1", st_sat); end
        do_reset();
        checks += 2;
        if ({err_sat, dur_sat, fin_sat, tout_sat, st_sat} !== '0) begin failures++; $display("FAIL midrst_sat got=%h exp=0", {err_sat, dur_sat, fin_sat, tout_sat, st_sat}); end
        if ({err_io, dur_io, fin_io, tout_io, st_io} !== '0) begin failures++; $display("FAIL midrst_io got=%h exp=0", {err_io, dur_io, fin_io, tout_io, st_io}); end
        for (int i = 0; i < 8; i++) write(ga[i], gd[i]);
        checks += 4;
        if (fin_sat !== 1'b1) begin failures++; $display("FAIL rerun_finish got=%b exp=1", fin_sat); end
        if (32'(err_sat) !== 0) begin failures++; $display("FAIL rerun_err got=%0d exp=0", err_sat); end
        if (32'(dur_sat) !== 8) begin failures++; $display("FAIL rerun_dur got=%0d exp=8", dur_sat); end
        if ({fin_io, err_io} !== 9'h100) begin failures++; $display("FAIL rerun_io got=%h exp=100", {fin_io, err_io}); end
    endtask

    task automatic test_random();
        int nw, e, ee, ed;
        bit ef;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int i = 0; i < 8; i++) load(i, {1'b0, 26'($urandom), i[2:0]}, $urandom);
            nw = $urandom_range(3, 12);
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 3)) step();
                e = $urandom_range(0, 8);
                if (e == 8) write({1'b1, 29'($urandom)}, $urandom);
                else write(ga[e], ($urandom_range(0, 3) == 0) ? gd[e] ^ 32'h1 : gd[e]);
            end
            while (cyc < 205) step();
            checks += 15;
            model(4, 50, 8, 1'b1, ee, ed, ef);
            if (32'(err_io) !== ee) begin failures++; $display("FAIL rnd%0d_io_err got=%0d exp=%0d", it, err_io, ee); end
            if (32'(dur_io) !== ed) begin failures++; $display("FAIL rnd%0d_io_dur got=%0d exp=%0d", it, dur_io, ed); end
            if (fin_io !== ef) begin failures++; $display("FAIL rnd%0d_io_fin got=%b exp=%b", it, fin_io, ef); end
            if (tout_io !== !ef) begin failures++; $display("FAIL rnd%0d_io_tout got=%b exp=%b", it, tout_io, !ef); end
            if (32'(st_io) !== (ef ? 2 : 3)) begin failures++; $display("FAIL rnd%0d_io_state got=%0d exp=%0d", it, st_io, ef ? 2 : 3); end
            model(4, 50, 8, 1'b0, ee, ed, ef);
            if (32'(err_ooo) !== ee) begin failures++; $display("FAIL rnd%0d_ooo_err got=%0d exp=%0d", it, err_ooo, ee); end
            if (32'(dur_ooo) !== ed) begin failures++; $display("FAIL rnd%0d_ooo_dur got=%0d exp=%0d", it, dur_ooo, ed); end
            if (fin_ooo !== ef) begin failures++; $display("FAIL rnd%0d_ooo_fin got=%b exp=%b", it, fin_ooo, ef); end
            if (tout_ooo !== !ef) begin failures++; $display("FAIL rnd%0d_ooo_tout got=%b exp=%b", it, tout_ooo, !ef); end
            if (32'(st_ooo) !== (ef ? 2 : 3)) begin failures++; $display("FAIL rnd%0d_ooo_state got=%0d exp=%0d", it, st_ooo, ef ? 2 : 3); end
            model(8, 200, 2, 1'b1, ee, ed, ef);
            if (32'(err_sat) !== ee) begin failures++; $display("FAIL rnd%0d_sat_err got=%0d exp=%0d", it, err_sat, ee); end
            if (32'(dur_sat) !== ed) begin failures++; $display("FAIL rnd%0d_sat_dur got=%0d exp=%0d", it, dur_sat, ed); end
            if (fin_sat !== ef) begin failures++; $display("FAIL rnd%0d_sat_fin got=%b exp=%b", it, fin_sat, ef); end
            if (tout_sat !== !ef) begin failures++; $display("FAIL rnd%0d_sat_tout got=%b exp=%b", it, tout_sat, !ef); end
            if (32'(st_sat) !== (ef ? 2 : 3)) begin failures++; $display("FAIL rnd%0d_sat_state got=%0d exp=%0d", it, st_sat, ef ? 2 : 3); end
        end
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ld_en = 1'b0; ld_idx = '0;
        addr = '0; data = '0; ld_addr = '0; ld_data = '0;
        test_reset();
        test_in_order();
        test_mismatch();
        test_ooo();
        test_latest();
        test_timeout();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
